// File: rtl/clk_period_meter_if.sv
// Control and result bus of the clock period meter.
// Master arms and stops measurements. Slave (the meter) reports results.
`timescale 1ns/1ps
interface clk_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             continuous;
  logic             stop;
  logic             rise_tick;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             in_range;
  logic             stalled;
  logic             busy;

  // start/stop are single-cycle strobes sampled on posedge clk_in.
  // meas_valid is a single-cycle strobe and has no backpressure: period,
  // high_time and in_range are stable from that strobe until the next one.
  modport master (
    output start, continuous, stop,
    input  rise_tick, period, high_time, meas_valid, in_range, stalled, busy
  );

  modport slave (
    input  start, continuous, stop,
    output rise_tick, period, high_time, meas_valid, in_range, stalled, busy
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous monitored clock in clk_in
// cycles, with single-shot or continuous operation and a sticky stall flag.
`timescale 1ns/1ps
module clk_period_meter #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000,
  parameter int MIN_PERIOD = 2,
  parameter int MAX_PERIOD = 65535
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 mon_clk,
  clk_period_meter_if.slave    bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_EDGE = 2'd1, MEASURE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MX = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   MIN_W  = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]   MAX_W  = (CNT_W+1)'(MAX_PERIOD);

  state_t           state_q, state_d;
  logic             s1, s2, h, rise;
  logic             rise_tick_q, meas_valid_q, in_range_q, stalled_q, cont_q;
  logic [CNT_W-1:0] cnt, hi_cnt, wcnt, period_q, high_q;
  logic             acc_start, capture, timeout;

  assign rise = s2 & ~h;

  always_comb begin
    state_d   = state_q;
    acc_start = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          acc_start = 1'b1;
          state_d   = WAIT_EDGE;
        end
      end
      WAIT_EDGE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = MEASURE;
        end else if (wcnt >= TO_M1) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      MEASURE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (rise) begin
          capture = 1'b1;
          state_d = cont_q ? MEASURE : IDLE;
        end else if (wcnt >= TO_M1) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      h            <= 1'b0;
      rise_tick_q  <= 1'b0;
      meas_valid_q <= 1'b0;
      in_range_q   <= 1'b0;
      stalled_q    <= 1'b0;
      cont_q       <= 1'b0;
      cnt          <= '0;
      hi_cnt       <= '0;
      wcnt         <= '0;
      period_q     <= '0;
      high_q       <= '0;
    end else begin
      s1           <= mon_clk;
      s2           <= s1;
      h            <= s2;
      rise_tick_q  <= rise;
      meas_valid_q <= capture;

      if (acc_start) begin
        stalled_q <= 1'b0;
        cont_q    <= bus.continuous;
        wcnt      <= '0;
      end else if (state_q != IDLE) begin
        wcnt <= rise ? '0 : ((wcnt != CNT_MX) ? wcnt + 1'b1 : wcnt);
      end

      if (timeout) stalled_q <= 1'b1;

      if (capture) begin
        period_q   <= cnt;
        high_q     <= hi_cnt;
        in_range_q <= ({1'b0, cnt} >= MIN_W) && ({1'b0, cnt} <= MAX_W);
      end

      // The edge that closes one period also opens the next one.
      if (rise) begin
        cnt    <= CNT_W'(1);
        hi_cnt <= CNT_W'(1);
      end else if (state_q == MEASURE) begin
        if (cnt != CNT_MX) cnt <= cnt + 1'b1;
        if (s2 && hi_cnt != CNT_MX) hi_cnt <= hi_cnt + 1'b1;
      end
    end
  end

  assign bus.rise_tick  = rise_tick_q;
  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.in_range   = in_range_q;
  assign bus.stalled    = stalled_q;
  assign bus.busy       = (state_q != IDLE);
  assign dbg_state      = state_q;

endmodule
